ucaspian_axon: RTL and testbench

Axon unit: accepts neuron fire events and expands each into a burst of consecutive synapse addresses for the synapse unit. Each of 256 neurons owns a contiguous synapse range, held in a per-neuron config RAM as a 10-bit start address and a 10-bit count. The block sits between the neuron/fire logic and the synapse unit. It drives the synapse unit's `syn_addr/syn_vld/syn_rdy` input handshake as the transmitter.

---
 rtl/ucaspian_axon.sv | 220 ++++++++++++++++++++++
 tb/tb_ucaspian_axon.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucaspian_axon.sv
// ucaspian_axon
// Axon unit: turns each neuron fire event into a burst of consecutive
// synapse addresses for the synapse unit. Each of the 256 neurons owns a
// contiguous range of the 1024-entry synapse space, described by a 10-bit
// start address and a 10-bit count held in a 256 x 20 config RAM.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   enable                allow new fires to be accepted
//   clear_act             abort any burst or pending lookup
//   clear_config          zero all config entries (held high until clear_done)
//   clear_done            clear complete
//   step_done             block idle with no pending work (registered)
//   cfg_addr/cfg_value/cfg_byte/cfg_enable
//                         byte-wise config write (bytes 0,1 stage, 2 commits)
//   axon_addr/axon_vld/axon_rdy
//                         fire event input handshake
//   syn_addr/syn_vld/syn_rdy
//                         synapse address output handshake
module ucaspian_axon (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear_act,
    input  logic       clear_config,
    output logic       clear_done,
    output logic       step_done,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_value,
    input  logic [2:0] cfg_byte,
    input  logic       cfg_enable,
    input  logic [7:0] axon_addr,
    input  logic       axon_vld,
    output logic       axon_rdy,
    output logic [9:0] syn_addr,
    output logic       syn_vld,
    input  logic       syn_rdy
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        EMIT
    } state_t;

    state_t     state_reg, state_next;
    logic [9:0] syn_addr_reg, syn_addr_next;
    logic [9:0] remaining_reg, remaining_next;
    logic       syn_vld_reg, syn_vld_next;

    logic [7:0] start_lo_reg;
    logic [7:0] count_lo_reg;

    // Clear sweep counter: bit 8 set means all 256 entries have been written.
    logic [8:0] clr_cnt_reg;
    logic       clr_flag_reg;
    logic       clear_done_reg;
    logic       step_done_reg;

    // Config RAM: [19:10] start, [9:0] count. Contents are never reset.
    logic [19:0] cfg_mem [256];
    logic [19:0] rd_data_reg;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [19:0] mem_wdata;

    logic       clear_any;
    logic       fire;
    logic [9:0] lookup_start;
    logic [9:0] lookup_count;

    // The top nibble of the commit byte carries no information.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_value[7:4];

    assign clear_any    = clear_act | clear_config;
    assign axon_rdy     = (state_reg == IDLE) & enable & ~clear_any & ~reset;
    assign fire         = axon_vld & axon_rdy;
    assign mem_re       = fire;
    assign lookup_start = rd_data_reg[19:10];
    assign lookup_count = rd_data_reg[9:0];

    // ------------------------------------------------------------------
    // Config RAM write port: the clear sweep owns the port while
    // clear_config is high; otherwise byte 2 commits the staged entry.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cfg_addr;
        mem_wdata = {cfg_value[1:0], start_lo_reg, cfg_value[3:2], count_lo_reg};
        if (clear_config) begin
            mem_we    = ~clr_cnt_reg[8];
            mem_waddr = clr_cnt_reg[7:0];
            mem_wdata = 20'd0;
        end else if (cfg_enable && !clear_act && cfg_byte == 3'd2) begin
            mem_we = 1'b1;
        end
    end

    // Registered read returns the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            cfg_mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            rd_data_reg <= cfg_mem[axon_addr];
        end
    end

    // Low-byte staging for the config write sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_lo_reg <= 8'd0;
            count_lo_reg <= 8'd0;
        end else if (cfg_enable && !clear_any) begin
            if (cfg_byte == 3'd0) begin
                start_lo_reg <= cfg_value;
            end
            if (cfg_byte == 3'd1) begin
                count_lo_reg <= cfg_value;
            end
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencing. clear_done reports an activity clear on the next
    // cycle, or follows the config-sweep flag with one cycle of delay.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || !clear_config) begin
            clr_cnt_reg  <= 9'd0;
            clr_flag_reg <= 1'b0;
        end else if (!clr_cnt_reg[8]) begin
            clr_cnt_reg <= clr_cnt_reg + 9'd1;
        end else begin
            clr_flag_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_done_reg <= 1'b0;
            step_done_reg  <= 1'b0;
        end else begin
            clear_done_reg <= clear_act | clr_flag_reg;
            step_done_reg  <= (state_reg == IDLE) & ~syn_vld_reg & ~axon_vld;
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            syn_addr_reg  <= 10'd0;
            remaining_reg <= 10'd0;
            syn_vld_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            syn_addr_reg  <= syn_addr_next;
            remaining_reg <= remaining_next;
            syn_vld_reg   <= syn_vld_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        syn_addr_next  = syn_addr_reg;
        remaining_next = remaining_reg;
        syn_vld_next   = syn_vld_reg;
        if (clear_any) begin
            // Abort drops the burst outright; no further beats are offered.
            state_next     = IDLE;
            syn_addr_next  = 10'd0;
            remaining_next = 10'd0;
            syn_vld_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fire) begin
                        state_next = LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookup_count == 10'd0) begin
                        state_next = IDLE;
                    end else begin
                        syn_addr_next  = lookup_start;
                        remaining_next = lookup_count;
                        syn_vld_next   = 1'b1;
                        state_next     = EMIT;
                    end
                end
                EMIT: begin
                    if (syn_vld_reg && syn_rdy) begin
                        if (remaining_reg == 10'd1) begin
                            syn_vld_next = 1'b0;
                            state_next   = IDLE;
                        end else begin
                            // 10-bit wrap is intended: ranges may cross 1023 -> 0.
                            syn_addr_next  = syn_addr_reg + 10'd1;
                            remaining_next = remaining_reg - 10'd1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign syn_addr   = syn_addr_reg;
    assign syn_vld    = syn_vld_reg;
    assign clear_done = clear_done_reg;
    assign step_done  = step_done_reg;

endmodule

// File: tb/tb_ucaspian_axon.sv
// Testbench for ucaspian_axon: directed scenarios plus a randomized phase.
// A reference model (per-neuron start/count table) turns every accepted
// fire into the list of synapse addresses it must produce; a monitor pops
// that list on every output handshake and compares.
module tb_ucaspian_axon;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear_act;
    logic       clear_config;
    logic       clear_done;
    logic       step_done;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_value;
    logic [2:0] cfg_byte;
    logic       cfg_enable;
    logic [7:0] axon_addr;
    logic       axon_vld;
    logic       axon_rdy;
    logic [9:0] syn_addr;
    logic       syn_vld;
    logic       syn_rdy = 1'b0;

    ucaspian_axon dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear_act    (clear_act),
        .clear_config (clear_config),
        .clear_done   (clear_done),
        .step_done    (step_done),
        .cfg_addr     (cfg_addr),
        .cfg_value    (cfg_value),
        .cfg_byte     (cfg_byte),
        .cfg_enable   (cfg_enable),
        .axon_addr    (axon_addr),
        .axon_vld     (axon_vld),
        .axon_rdy     (axon_rdy),
        .syn_addr     (syn_addr),
        .syn_vld      (syn_vld),
        .syn_rdy      (syn_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model
    int cfg_start [256];
    int cfg_cnt   [256];
    int exp_q [$];
    int exp_first = -1;
    int beat_cnt  = 0;

    // syn_rdy driver: random or directed
    bit   rdy_rand = 1'b0;
    logic rdy_dir  = 1'b0;
    always @(posedge clk) begin
        #2;
        syn_rdy = rdy_rand ? 1'($urandom % 2) : rdy_dir;
    end

    // Monitor / scoreboard
    logic       prev_vld  = 1'b0;
    logic       prev_rdy  = 1'b0;
    logic       prev_clr  = 1'b1;
    logic [9:0] prev_addr = 10'd0;

    always @(negedge clk) begin
        if (prev_vld && !prev_rdy && !prev_clr) begin
            chk("stall_vld_held", int'(syn_vld), 1);
            chk("stall_addr_held", int'(syn_addr), int'(prev_addr));
        end
        if (syn_vld === 1'b1 && !prev_vld && !reset) begin
            chk("first_beat_cycle", cyc, exp_first);
            exp_first = -1;
        end
        if (reset || clear_act || clear_config) begin
            exp_q.delete();
            exp_first = -1;
        end else begin
            if (syn_vld && syn_rdy) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    chk("beat_extra_addr", int'(syn_addr), 1024);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("beat_addr", int'(syn_addr), e);
                end
            end
            if (axon_vld && axon_rdy) begin
                int a;
                a = int'(axon_addr);
                for (int i = 0; i < cfg_cnt[a]; i++)
                    exp_q.push_back((cfg_start[a] + i) % 1024);
                exp_first = (cfg_cnt[a] > 0) ? cyc + 2 : -1;
            end
        end
        prev_vld  = (syn_vld === 1'b1);
        prev_rdy  = syn_rdy;
        prev_clr  = reset || clear_act || clear_config;
        prev_addr = syn_addr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int n, input int start, input int cnt);
        cfg_enable = 1'b1;
        cfg_addr   = 8'(n);
        cfg_byte   = 3'd0;
        cfg_value  = 8'(start);
        tick();
        cfg_byte   = 3'd1;
        cfg_value  = 8'(cnt);
        tick();
        cfg_byte   = 3'd2;
        cfg_value  = {4'b0, 2'(cnt >> 8), 2'(start >> 8)};
        tick();
        cfg_enable = 1'b0;
        cfg_byte   = 3'd3;
        cfg_start[n] = start;
        cfg_cnt[n]   = cnt;
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic fire(input int n);
        axon_addr = 8'(n);
        axon_vld  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (axon_rdy) begin
                @(posedge clk);
                #1;
                axon_vld = 1'b0;
                return;
            end
        end
        chk("fire_accept_timeout", int'(axon_rdy), 1);
        axon_vld = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!syn_vld && exp_q.size() == 0) begin
                tick();
                return;
            end
        end
        chk("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int k;
        reset        = 1'b1;
        enable       = 1'b1;
        clear_act    = 1'b0;
        clear_config = 1'b0;
        cfg_addr     = 8'd0;
        cfg_value    = 8'd0;
        cfg_byte     = 3'd3;
        cfg_enable   = 1'b0;
        axon_addr    = 8'd0;
        axon_vld     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_axon_rdy", int'(axon_rdy), 0);
        chk("reset_syn_vld", int'(syn_vld), 0);
        chk("reset_syn_addr", int'(syn_addr), 0);
        chk("reset_clear_done", int'(clear_done), 0);
        chk("reset_step_done", int'(step_done), 0);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_step_done", int'(step_done), 1);
        chk("idle_axon_rdy", int'(axon_rdy), 1);
        tick();

        // Basic burst of 3
        cfg_write(5, 100, 3);
        rdy_dir = 1'b1;
        b0 = beat_cnt;
        fire(5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("burst3_vld_low_after", int'(syn_vld), 0);
        chk("burst3_rdy_after", int'(axon_rdy), 1);
        chk("burst3_beats", beat_cnt - b0, 3);
        tick();

        // Wrap-around
        cfg_write(7, 1022, 4);
        b0 = beat_cnt;
        fire(7);
        drain(50);
        chk("wrap_beats", beat_cnt - b0, 4);

        // Zero count
        cfg_write(11, 55, 0);
        fire(11);
        @(negedge clk);
        chk("zero_cnt_lookup_rdy", int'(axon_rdy), 0);
        @(negedge clk);
        chk("zero_cnt_idle_rdy", int'(axon_rdy), 1);
        chk("zero_cnt_no_vld", int'(syn_vld), 0);
        tick();

        // Stalled burst: syn_rdy 1,0,0,1,1
        cfg_write(12, 300, 3);
        rdy_dir = 1'b0;
        b0 = beat_cnt;
        fire(12);
        tick(); rdy_dir = 1'b1;
        tick(); rdy_dir = 1'b0;
        tick(); rdy_dir = 1'b0;
        tick(); rdy_dir = 1'b1;
        tick(); rdy_dir = 1'b1;
        tick(); rdy_dir = 1'b0;
        @(negedge clk);
        chk("stall_vld_low_after", int'(syn_vld), 0);
        chk("stall_beats", beat_cnt - b0, 3);
        tick();

        // enable low blocks acceptance
        enable = 1'b0;
        @(negedge clk);
        chk("enable_low_rdy", int'(axon_rdy), 0);
        tick();
        enable = 1'b1;

        // Mid-burst clear_act
        cfg_write(9, 200, 5);
        rdy_dir = 1'b1;
        b0 = beat_cnt;
        fire(9);
        tick();
        tick();
        clear_act = 1'b1;
        rdy_dir   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("clear_act_vld", int'(syn_vld), 0);
        chk("clear_act_done", int'(clear_done), 1);
        chk("clear_act_addr", int'(syn_addr), 0);
        chk("clear_act_beats", beat_cnt - b0, 1);
        tick();
        clear_act = 1'b0;
        rdy_dir   = 1'b1;
        repeat (5) tick();
        chk("no_beats_after_clear", beat_cnt - b0, 1);
        chk("clear_done_falls", int'(clear_done), 0);

        // Maximum count
        cfg_write(20, 512, 1023);
        b0 = beat_cnt;
        fire(20);
        drain(1100);
        chk("max_count_beats", beat_cnt - b0, 1023);

        // Randomized phase
        for (int n = 30; n < 46; n++)
            cfg_write(n, int'($urandom_range(0, 1023)), int'($urandom_range(0, 40)));
        rdy_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            fire(int'($urandom_range(30, 45)));
            if ($urandom % 3 == 0) begin
                enable = 1'b0;
                @(negedge clk);
                chk("enable_low_midburst_rdy", int'(axon_rdy), 0);
                tick();
                enable = 1'b1;
            end
        end
        drain(4000);
        rdy_rand = 1'b0;
        rdy_dir  = 1'b1;
        tick();

        // clear_config sweep
        clear_config = 1'b1;
        k = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (clear_done) begin
                k = i;
                break;
            end
        end
        chk("clear_config_latency", k, 258);
        tick();
        clear_config = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("clear_config_done_falls", int'(clear_done), 0);
        tick();
        for (int n = 0; n < 256; n++) begin
            cfg_start[n] = 0;
            cfg_cnt[n]   = 0;
        end
        b0 = beat_cnt;
        foreach (cfg_cnt[n]) if (n % 37 == 5) fire(n);
        repeat (4) tick();
        chk("cleared_no_beats", beat_cnt - b0, 0);

        // step_done
        repeat (3) tick();
        @(negedge clk);
        chk("step_done_idle", int'(step_done), 1);
        tick();
        enable   = 1'b0;
        axon_vld = 1'b1;
        tick();
        @(negedge clk);
        chk("step_done_vld_pending", int'(step_done), 0);
        tick();
        axon_vld = 1'b0;
        enable   = 1'b1;
        tick();

        chk("queue_empty_at_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
